// File: rtl/count_bcd_7seg_disp_if.sv
// Bundles the counter value going into the BCD/7-segment display stage
// with the converted result and the multiplexed display drive coming out.
interface count_bcd_7seg_disp_if #(
    parameter int N      = 6,
    parameter int DIGITS = 2
);
    logic [N-1:0]        bin_in;
    logic [4*DIGITS-1:0] bcd_out;
    logic                conv_done;
    logic                busy;
    logic [6:0]          seg;
    logic [DIGITS-1:0]   an;

    modport master (
        output bin_in,
        input  bcd_out,
        input  conv_done,
        input  busy,
        input  seg,
        input  an
    );

    modport slave (
        input  bin_in,
        output bcd_out,
        output conv_done,
        output busy,
        output seg,
        output an
    );
endinterface

// File: rtl/count_bcd_7seg_disp.sv
// Converts the free-running counter value to BCD with a one-shift-per-cycle
// double-dabble engine and scans the digits onto a multiplexed 7-segment display.
module count_bcd_7seg_disp #(
    parameter int N              = 6,
    parameter int DIGITS         = 2,
    parameter int REFRESH_DIV    = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1,
    parameter bit BLANK_LZ       = 1'b1
) (
    input logic                  i_clk,
    input logic                  i_clr_n,
    count_bcd_7seg_disp_if.slave bus
);

    localparam int BCD_W  = 4 * DIGITS;
    localparam int SR_W   = BCD_W + N;
    localparam int ITER_W = (N > 1) ? $clog2(N) : 1;
    localparam int REF_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int DIG_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [6:0]        SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [DIGITS-1:0] AN_OFF  = AN_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t              r_state;
    state_t              w_nextState;
    logic                w_start;
    logic                w_load;
    logic                w_shiftEn;
    logic                w_done;
    logic                w_busy;

    logic                r_valid;
    logic [N-1:0]        r_lastVal;
    logic [SR_W-1:0]     r_shift;
    logic [SR_W-1:0]     w_adj;
    logic [ITER_W-1:0]   r_iter;
    logic [BCD_W-1:0]    r_bcdOut;
    logic                r_convDone;

    logic [REF_W-1:0]    r_refresh;
    logic [DIG_W-1:0]    r_digit;
    logic [DIGITS-1:0]   w_blankVec;
    logic                w_zeroAbove;
    logic [3:0]          w_curNibble;
    logic [6:0]          w_segRaw;
    logic [DIGITS-1:0]   w_oneHot;
    logic [6:0]          r_seg;
    logic [DIGITS-1:0]   r_an;

    function automatic logic [6:0] decodeDigit(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0111111;
            4'd1:    s = 7'b0000110;
            4'd2:    s = 7'b1011011;
            4'd3:    s = 7'b1001111;
            4'd4:    s = 7'b1100110;
            4'd5:    s = 7'b1101101;
            4'd6:    s = 7'b1111101;
            4'd7:    s = 7'b0000111;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1101111;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    always_ff @(posedge i_clk or negedge i_clr_n) begin
        if (!i_clr_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // A cleared valid flag forces one conversion even if bin_in matches the stale last value.
    always_comb begin
        w_nextState = r_state;
        w_load      = 1'b0;
        w_shiftEn   = 1'b0;
        w_done      = 1'b0;
        w_busy      = 1'b0;
        w_start     = !r_valid || (bus.bin_in != r_lastVal);
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_load      = 1'b1;
                    w_nextState = SHIFT;
                end
            end
            SHIFT: begin
                w_busy    = 1'b1;
                w_shiftEn = 1'b1;
                if (r_iter == ITER_W'(N - 1)) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                w_busy      = 1'b1;
                w_done      = 1'b1;
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    always_comb begin
        w_adj = r_shift;
        for (int d = 0; d < DIGITS; d++) begin
            if (r_shift[N+4*d +: 4] >= 4'd5) begin
                w_adj[N+4*d +: 4] = r_shift[N+4*d +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_clr_n) begin
        if (!i_clr_n) begin
            r_shift    <= '0;
            r_lastVal  <= '0;
            r_valid    <= 1'b0;
            r_iter     <= '0;
            r_bcdOut   <= '0;
            r_convDone <= 1'b0;
        end else begin
            r_convDone <= w_done;
            if (w_load) begin
                r_shift   <= {{BCD_W{1'b0}}, bus.bin_in};
                r_lastVal <= bus.bin_in;
                r_valid   <= 1'b1;
                r_iter    <= '0;
            end else if (w_shiftEn) begin
                r_shift <= w_adj << 1;
                r_iter  <= r_iter + ITER_W'(1);
            end
            if (w_done) begin
                r_bcdOut <= r_shift[SR_W-1 -: BCD_W];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_clr_n) begin
        if (!i_clr_n) begin
            r_refresh <= '0;
            r_digit   <= '0;
        end else if (r_refresh == REF_W'(REFRESH_DIV - 1)) begin
            r_refresh <= '0;
            r_digit   <= (r_digit == DIG_W'(DIGITS - 1)) ? '0 : r_digit + DIG_W'(1);
        end else begin
            r_refresh <= r_refresh + REF_W'(1);
        end
    end

    // Walk from the most significant digit down so a digit blanks only when everything above it is zero too.
    always_comb begin
        w_zeroAbove = 1'b1;
        w_blankVec  = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            w_zeroAbove   = w_zeroAbove && (r_bcdOut[4*k +: 4] == 4'd0);
            w_blankVec[k] = BLANK_LZ && (k != 0) && w_zeroAbove;
        end
    end

    always_comb begin
        w_curNibble = r_bcdOut[4*r_digit +: 4];
        w_segRaw    = w_blankVec[r_digit] ? 7'b0000000 : decodeDigit(w_curNibble);
        w_oneHot    = DIGITS'(1) << r_digit;
    end

    always_ff @(posedge i_clk or negedge i_clr_n) begin
        if (!i_clr_n) begin
            r_seg <= SEG_OFF;
            r_an  <= AN_OFF;
        end else begin
            r_seg <= SEG_ACTIVE_LOW ? ~w_segRaw : w_segRaw;
            r_an  <= AN_ACTIVE_LOW ? ~w_oneHot : w_oneHot;
        end
    end

    assign bus.bcd_out   = r_bcdOut;
    assign bus.conv_done = r_convDone;
    assign bus.busy      = w_busy;
    assign bus.seg       = r_seg;
    assign bus.an        = r_an;

endmodule

// File: tb/tb_count_bcd_7seg_disp.sv
// Directed bench for the BCD / 7-segment display stage: a vector table of
// counter values with hand-worked BCD and segment patterns, plus corner sequences.
module tb_count_bcd_7seg_disp;

    localparam int N      = 6;
    localparam int DIGITS = 2;

    typedef struct {
        logic [5:0] binVal;
        logic [7:0] expBcd;
        logic [6:0] expSeg0;
        logic [6:0] expSeg1;
    } vec_t;

    logic clk  = 1'b0;
    logic clrN = 1'b0;
    int   vecCount  = 0;
    int   missCount = 0;
    vec_t vecTable[10];

    always #5 clk = ~clk;

    count_bcd_7seg_disp_if #(.N(N), .DIGITS(DIGITS)) dispIf ();

    count_bcd_7seg_disp #(
        .N(N),
        .DIGITS(DIGITS),
        .REFRESH_DIV(4),
        .SEG_ACTIVE_LOW(1'b0),
        .AN_ACTIVE_LOW(1'b0),
        .BLANK_LZ(1'b1)
    ) dut (
        .i_clk(clk),
        .i_clr_n(clrN),
        .bus(dispIf.slave)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vecCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [5:0] v);
        @(negedge clk);
        dispIf.bin_in = v;
    endtask

    // Watches 20 edges after a new value is driven: one pulse on edge 8, busy for 7 cycles, then quiet.
    task automatic runConversion(input logic [7:0] expBcd, input string name);
        int busyCnt   = 0;
        int doneCnt   = 0;
        int doneEdge  = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (dispIf.busy) busyCnt++;
            if (dispIf.conv_done) begin
                doneCnt++;
                if (doneEdge == 0) doneEdge = k;
            end
        end
        checkOutput($sformatf("%s doneEdge", name), doneEdge, 8);
        checkOutput($sformatf("%s doneCount", name), doneCnt, 1);
        checkOutput($sformatf("%s busyCycles", name), busyCnt, 7);
        checkOutput($sformatf("%s bcd_out", name), dispIf.bcd_out, expBcd);
    endtask

    task automatic checkDisplay(input logic [6:0] seg0, input logic [6:0] seg1, input string name);
        bit seen0  = 0;
        bit seen1  = 0;
        int badAn  = 0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (dispIf.an == 2'b01 && !seen0) begin
                seen0 = 1;
                checkOutput($sformatf("%s digit0 seg", name), dispIf.seg, seg0);
            end else if (dispIf.an == 2'b10 && !seen1) begin
                seen1 = 1;
                checkOutput($sformatf("%s digit1 seg", name), dispIf.seg, seg1);
            end
            if (dispIf.an != 2'b01 && dispIf.an != 2'b10) badAn++;
        end
        checkOutput($sformatf("%s bothDigitsScanned", name), {30'd0, seen1, seen0}, 32'd3);
        checkOutput($sformatf("%s anOneHot", name), badAn, 0);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit       found;
        logic [1:0] prevAn;
        logic [1:0] expAn;
        logic [6:0] expSeg;

        vecTable[0] = '{6'd63, 8'h63, 7'b1001111, 7'b1111101};
        vecTable[1] = '{6'd37, 8'h37, 7'b0000111, 7'b1001111};
        vecTable[2] = '{6'd5,  8'h05, 7'b1101101, 7'b0000000};
        vecTable[3] = '{6'd10, 8'h10, 7'b0111111, 7'b0000110};
        vecTable[4] = '{6'd9,  8'h09, 7'b1101111, 7'b0000000};
        vecTable[5] = '{6'd20, 8'h20, 7'b0111111, 7'b1011011};
        vecTable[6] = '{6'd48, 8'h48, 7'b1111111, 7'b1100110};
        vecTable[7] = '{6'd1,  8'h01, 7'b0000110, 7'b0000000};
        vecTable[8] = '{6'd62, 8'h62, 7'b1011011, 7'b1111101};
        vecTable[9] = '{6'd24, 8'h24, 7'b1100110, 7'b1011011};

        dispIf.bin_in = 6'd0;
        clrN = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset bcd_out", dispIf.bcd_out, 8'h00);
        checkOutput("reset conv_done", dispIf.conv_done, 1'b0);
        checkOutput("reset busy", dispIf.busy, 1'b0);
        checkOutput("reset seg", dispIf.seg, 7'b0000000);
        checkOutput("reset an", dispIf.an, 2'b00);

        $display("[TB] release reset with bin_in=0");
        clrN = 1'b1;
        runConversion(8'h00, "postReset");
        checkDisplay(7'b0111111, 7'b0000000, "postReset");

        $display("[TB] vector table");
        for (int v = 0; v < 10; v++) begin
            applyStimulus(vecTable[v].binVal);
            runConversion(vecTable[v].expBcd, $sformatf("vec%0d", v));
            checkDisplay(vecTable[v].expSeg0, vecTable[v].expSeg1, $sformatf("vec%0d", v));
        end

        $display("[TB] bin_in change during SHIFT");
        applyStimulus(6'd45);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k == 3) dispIf.bin_in = 6'd12;
            if (k == 7) checkOutput("midChange bcd before done", dispIf.bcd_out, 8'h24);
            if (k == 8) begin
                checkOutput("midChange first pulse", dispIf.conv_done, 1'b1);
                checkOutput("midChange first bcd", dispIf.bcd_out, 8'h45);
                checkOutput("midChange idle gap busy", dispIf.busy, 1'b0);
            end
            if (k == 9) begin
                checkOutput("midChange restart busy", dispIf.busy, 1'b1);
                checkOutput("midChange restart pulse", dispIf.conv_done, 1'b0);
            end
            if (k == 15) checkOutput("midChange early pulse", dispIf.conv_done, 1'b0);
            if (k == 16) begin
                checkOutput("midChange second pulse", dispIf.conv_done, 1'b1);
                checkOutput("midChange second bcd", dispIf.bcd_out, 8'h12);
            end
        end

        $display("[TB] scan timing with bin_in=37");
        applyStimulus(6'd37);
        runConversion(8'h37, "scan");
        found  = 0;
        prevAn = dispIf.an;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (dispIf.an == 2'b01 && prevAn == 2'b10) found = 1;
            prevAn = dispIf.an;
        end
        checkOutput("scan an wrap seen", found, 1'b1);
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clk);
            expAn  = ((i / 4) % 2 == 1) ? 2'b10 : 2'b01;
            expSeg = ((i / 4) % 2 == 1) ? 7'b1001111 : 7'b0000111;
            checkOutput($sformatf("scan an[%0d]", i), dispIf.an, expAn);
            checkOutput($sformatf("scan seg[%0d]", i), dispIf.seg, expSeg);
        end

        $display("[TB] reset during SHIFT");
        applyStimulus(6'd0);
        runConversion(8'h00, "preAbort");
        applyStimulus(6'd50);
        repeat (3) @(negedge clk);
        checkOutput("abort busy before reset", dispIf.busy, 1'b1);
        #2;
        clrN = 1'b0;
        #1;
        checkOutput("abort bcd_out", dispIf.bcd_out, 8'h00);
        checkOutput("abort busy", dispIf.busy, 1'b0);
        checkOutput("abort conv_done", dispIf.conv_done, 1'b0);
        checkOutput("abort seg", dispIf.seg, 7'b0000000);
        checkOutput("abort an", dispIf.an, 2'b00);
        @(negedge clk);
        clrN = 1'b1;
        runConversion(8'h50, "postAbort");
        checkDisplay(7'b0111111, 7'b1101101, "postAbort");

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
